// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM RW-port controller.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 8;
  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_SEL_W  = SRAM_DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACC  = 3'd1,
    ST_CAP  = 3'd2,
    ST_WB   = 3'd3,
    ST_ACK  = 3'd4
  } state_t;

  // Byte i comes from new_d when sel[i] is set, otherwise from old_d.
  function automatic logic [SRAM_DATA_W-1:0] byte_merge(
    input logic [SRAM_DATA_W-1:0] old_d,
    input logic [SRAM_DATA_W-1:0] new_d,
    input logic [SRAM_SEL_W-1:0]  sel
  );
    logic [SRAM_DATA_W-1:0] m;
    m = old_d;
    for (int i = 0; i < SRAM_SEL_W; i++)
      if (sel[i]) m[8*i +: 8] = new_d[8*i +: 8];
    return m;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, registered pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  input  logic       i_adv_id,
  output logic       o_gnt_vld,
  output logic       o_gnt_id
);

  logic r_ptr;

  // Pointer holder wins a tie; a lone requester wins regardless of pointer.
  always_comb begin
    o_gnt_vld = |i_req;
    o_gnt_id  = (&i_req) ? r_ptr : i_req[1];
  end

  // After a completed access, priority passes to the other requester.
  always_ff @(posedge clk) begin
    if (!rst_n)     r_ptr <= 1'b0;
    else if (i_adv) r_ptr <= ~i_adv_id;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// RW-port controller for the 256x32 SRAM macro: two Wishbone-classic
// requesters, round-robin shared, partial writes done as read-modify-write.
import sram_ctrl_pkg::*;

module sram_port_arbiter #(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_stb,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_adr,
  input  logic [DATA_W-1:0]   m0_dat_w,
  input  logic [DATA_W/8-1:0] m0_sel,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_dat_r,
  input  logic                m1_stb,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_adr,
  input  logic [DATA_W-1:0]   m1_dat_w,
  input  logic [DATA_W/8-1:0] m1_sel,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_dat_r,
  output logic                sram_clk0,
  output logic                sram_csb0,
  output logic                sram_web0,
  output logic [ADDR_W-1:0]   sram_addr0,
  output logic [DATA_W-1:0]   sram_din0,
  input  logic [DATA_W-1:0]   sram_dout0
);

  localparam int SEL_W = DATA_W / 8;

  state_t              r_state;
  logic                r_id;
  logic                r_we;
  logic [DATA_W-1:0]   r_dat;
  logic [SEL_W-1:0]    r_sel;
  logic [DATA_W-1:0]   r_rbuf;
  logic [DATA_W-1:0]   r_dat_r0;
  logic [DATA_W-1:0]   r_dat_r1;

  logic                w_gnt_vld;
  logic                w_gnt_id;
  logic                w_we;
  logic [ADDR_W-1:0]   w_adr;
  logic [DATA_W-1:0]   w_dat;
  logic [SEL_W-1:0]    w_sel;
  logic                w_full;
  logic                w_none;
  logic                w_to_ack;
  logic [DATA_W-1:0]   w_buf_nxt;

  assign sram_clk0 = clk;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     ({m1_stb, m0_stb}),
    .i_adv     (r_state == ST_ACK),
    .i_adv_id  (r_id),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_id  (w_gnt_id)
  );

  // Selected requester's request fields and the latched-request decode.
  always_comb begin
    w_we   = w_gnt_id ? m1_we    : m0_we;
    w_adr  = w_gnt_id ? m1_adr   : m0_adr;
    w_dat  = w_gnt_id ? m1_dat_w : m0_dat_w;
    w_sel  = w_gnt_id ? m1_sel   : m0_sel;
    w_full = &r_sel;
    w_none = (r_sel == '0);
    // A sel==0 write walks the read path for timing but never strobes,
    // so the macro output is not captured for it.
    w_buf_nxt = (r_state == ST_CAP && !(r_we && w_none)) ? sram_dout0 : r_rbuf;
    w_to_ack  = (r_state == ST_ACC && r_we && w_full) ||
                (r_state == ST_CAP && !(r_we && !w_none)) ||
                (r_state == ST_WB);
  end

  assign m0_ack   = (r_state == ST_ACK) && !r_id;
  assign m1_ack   = (r_state == ST_ACK) &&  r_id;
  assign m0_dat_r = r_dat_r0;
  assign m1_dat_r = r_dat_r1;

  // Access sequencer; macro strobes are registered one cycle ahead of use.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_id       <= 1'b0;
      r_we       <= 1'b0;
      r_dat      <= '0;
      r_sel      <= '0;
      r_rbuf     <= '0;
      r_dat_r0   <= '0;
      r_dat_r1   <= '0;
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
    end else begin
      if (w_to_ack) begin
        if (r_id) r_dat_r1 <= w_buf_nxt;
        else      r_dat_r0 <= w_buf_nxt;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_id       <= w_gnt_id;
            r_we       <= w_we;
            r_dat      <= w_dat;
            r_sel      <= w_sel;
            sram_addr0 <= w_adr;
            sram_din0  <= w_dat;
            sram_csb0  <= w_we && (w_sel == '0);
            sram_web0  <= !(w_we && (&w_sel));
            r_state    <= ST_ACC;
          end
        end
        ST_ACC: begin
          sram_csb0 <= 1'b1;
          sram_web0 <= 1'b1;
          r_state   <= (r_we && w_full) ? ST_ACK : ST_CAP;
        end
        ST_CAP: begin
          r_rbuf <= w_buf_nxt;
          if (r_we && !w_none) begin
            sram_csb0 <= 1'b0;
            sram_web0 <= 1'b0;
            sram_din0 <= byte_merge(sram_dout0, r_dat, r_sel);
            r_state   <= ST_WB;
          end else begin
            r_state   <= ST_ACK;
          end
        end
        ST_WB: begin
          sram_csb0 <= 1'b1;
          sram_web0 <= 1'b1;
          r_state   <= ST_ACK;
        end
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural macro model and
// a read-data scoreboard.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_stb = 0, m0_we = 0, m1_stb = 0, m1_we = 0;
  logic [7:0]  m0_adr = 0, m1_adr = 0;
  logic [31:0] m0_dat_w = 0, m1_dat_w = 0;
  logic [3:0]  m0_sel = 0, m1_sel = 0;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_dat_r, m1_dat_r;
  logic        sram_clk0, sram_csb0, sram_web0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0 = 0;

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat_w(m0_dat_w),
    .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_dat_r(m0_dat_r),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dat_w(m1_dat_w),
    .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_dat_r(m1_dat_r),
    .sram_clk0(sram_clk0), .sram_csb0(sram_csb0), .sram_web0(sram_web0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  // Macro model: registered read data, available one edge after the strobe.
  logic [31:0] mem  [256];
  logic [31:0] rmem [256];
  int n_strb = 0;
  bit strb_web [$];
  always @(posedge clk) begin
    if (!sram_csb0) begin
      n_strb++;
      strb_web.push_back(sram_web0);
      if (!sram_web0) mem[sram_addr0] <= sram_din0;
      else            sram_dout0 <= mem[sram_addr0];
    end
  end

  typedef struct { bit id; logic [31:0] d; } exp_t;
  exp_t sb [$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge_ref(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction

  task automatic chk_rst(input string tag);
    chk({tag, " csb0"}, sram_csb0, 1);
    chk({tag, " web0"}, sram_web0, 1);
    chk({tag, " addr0"}, sram_addr0, 0);
    chk({tag, " din0"}, sram_din0, 0);
    chk({tag, " acks"}, {m0_ack, m1_ack}, 0);
    chk({tag, " dat_r0"}, m0_dat_r, 0);
    chk({tag, " dat_r1"}, m1_dat_r, 0);
  endtask

  // One request from a single requester; lat counts edges from grant edge t.
  task automatic xfer(input bit id, input bit we, input logic [7:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      input int exp_lat, input int exp_strb, input string tag,
                      input bit chg);
    int s0, lat;
    logic [31:0] other0;
    exp_t e;
    @(negedge clk);
    if (id) begin m1_stb = 1; m1_we = we; m1_adr = adr; m1_dat_w = dat; m1_sel = sel; end
    else    begin m0_stb = 1; m0_we = we; m0_adr = adr; m0_dat_w = dat; m0_sel = sel; end
    if (we) rmem[adr] = merge_ref(rmem[adr], dat, sel);
    else begin e.id = id; e.d = rmem[adr]; sb.push_back(e); end
    other0 = id ? m0_dat_r : m1_dat_r;
    s0 = n_strb;
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (chg && k == 1) begin
        if (id) begin m1_adr = adr + 8'd1; m1_dat_w = ~dat; end
        else    begin m0_adr = adr + 8'd1; m0_dat_w = ~dat; end
      end
      if ((id ? m1_ack : m0_ack) === 1'b1) lat = k;
      chk({tag, " other_ack"}, id ? m0_ack : m1_ack, 0);
    end
    chk({tag, " latency"}, lat, exp_lat);
    if (lat != 0) begin
      if (!we && sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, " rdata"}, id ? m1_dat_r : m0_dat_r, e.d);
      end
      chk({tag, " other_dat_r_hold"}, id ? m0_dat_r : m1_dat_r, other0);
    end
    chk({tag, " strobes"}, n_strb - s0, exp_strb);
    @(negedge clk);
    if (id) m1_stb = 0; else m0_stb = 0;
  endtask

  initial begin
    exp_t e;
    int n;
    for (int i = 0; i < 256; i++) begin mem[i] = 0; rmem[i] = 0; end

    repeat (3) @(posedge clk);
    #1 chk_rst("reset");
    @(negedge clk) rst_n = 1;

    // full write then read back
    xfer(0, 1, 8'h10, 32'hDEADBEEF, 4'hF, 2, 1, "m0_wr", 0);
    xfer(0, 0, 8'h10, 32'h0, 4'hF, 3, 1, "m0_rd", 0);

    // preload then partial write from m1
    xfer(0, 1, 8'h20, 32'h11223344, 4'hF, 2, 1, "preload", 0);
    xfer(1, 1, 8'h20, 32'hAABBCCDD, 4'h5, 4, 2, "m1_rmw", 0);
    chk("rmw_mem", mem[8'h20], 32'h11BB33DD);
    chk("rmw_web_seq", {30'd0, strb_web[strb_web.size()-2], strb_web[strb_web.size()-1]}, 2);
    xfer(1, 0, 8'h20, 32'h0, 4'hF, 3, 1, "m1_rd_rmw", 0);

    // sel==0 write leaves memory alone
    xfer(0, 1, 8'h20, 32'hFFFFFFFF, 4'h0, 3, 0, "sel0_wr", 0);
    chk("sel0_mem", mem[8'h20], 32'h11BB33DD);
    xfer(0, 0, 8'h20, 32'h0, 4'hF, 3, 1, "sel0_rd", 0);

    // inputs changed after grant are ignored
    xfer(1, 1, 8'h30, 32'h12345678, 4'hF, 2, 1, "latch_wr", 1);
    xfer(1, 0, 8'h30, 32'h0, 4'hF, 3, 1, "latch_rd", 0);
    xfer(1, 0, 8'h31, 32'h0, 4'hF, 3, 1, "latch_rd_nxt", 0);

    // reset while a read sits in CAP
    @(negedge clk);
    m0_stb = 1; m0_we = 0; m0_adr = 8'h10; m0_sel = 4'hF;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst_n = 0;
    @(posedge clk); #1 chk_rst("rst_cap");
    @(negedge clk); m0_stb = 0; rst_n = 1;
    xfer(0, 0, 8'h10, 32'h0, 4'hF, 3, 1, "rd_after_rst", 0);

    // both requesters held high from reset: m0, m1, m0, m1
    @(negedge clk) rst_n = 0;
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    m0_stb = 1; m0_we = 0; m0_adr = 8'h10; m0_sel = 4'hF;
    m1_stb = 1; m1_we = 0; m1_adr = 8'h20; m1_sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      e.id = i[0];
      e.d  = i[0] ? rmem[8'h20] : rmem[8'h10];
      sb.push_back(e);
    end
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(posedge clk); #1;
      chk("both_ack_overlap", m0_ack & m1_ack, 0);
      if ((m0_ack || m1_ack) && sb.size() > 0) begin
        e = sb.pop_front();
        chk("both_grant_id", m1_ack, e.id);
        chk("both_rdata", m1_ack ? m1_dat_r : m0_dat_r, e.d);
        n++;
      end
    end
    chk("both_grant_count", n, 4);
    @(negedge clk); m0_stb = 0; m1_stb = 0;
    repeat (2) @(posedge clk);
    #1 chk("idle_acks", {m0_ack, m1_ack}, 0);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
